rx_byte_store: RTL and testbench
================================

// Module: rx_byte_store
// PURPOSE
//   Receive-side byte store: captures each byte delivered by the UART receiver into a
//   circular DEPTH x 8 buffer and lets downstream logic drain it in order. It is the
//   sink counterpart of the transmit-side byte source, sitting between uart_rx and
//   the consumer. It detects message terminators and flags overruns.
// PARAMETERS
//   DEPTH      8      number of byte entries; 2..256, need not be a power of 2
//   TERM_BYTE  8'h0A  byte value that marks end of message
// PORTS
//   clk        in   1      single system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   rx_valid   in   1      one-cycle strobe: rx_data holds a received byte
//   rx_data    in   8      received byte
//   frame_err  in   1      [RX_FRAME_ERR_EN only] byte on rx_data has a framing error
//   rd_en      in   1      request next byte; honoured only when !empty
//   rd_data    out  8      byte read; valid while rd_valid=1
//   rd_valid   out  1      one-cycle pulse, 1 cycle after an accepted rd_en
//   empty      out  1      count==0
//   full       out  1      count==DEPTH
//   count      out  $clog2(DEPTH+1)  bytes currently held
//   overrun    out  1      sticky: a byte was dropped because the store was full
//   clr_ovr    in   1      synchronous clear of overrun
//   msg_done   out  1      one-cycle pulse, 1 cycle after TERM_BYTE is stored
//   err_cnt    out  8      [RX_FRAME_ERR_EN only] saturating count of dropped bad bytes
// BEHAVIOUR
//   - Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count=0, rd_data=0, rd_valid=0,
//     overrun=0, msg_done=0, err_cnt=0; empty=1, full=0. Memory contents are not cleared.
//   - Reset mid-operation discards all held bytes and any pending rd_valid/msg_done.
//   - Write accept: rx_valid=1 && !full, where full is sampled before the edge. The
//     byte goes to mem[wr_ptr]; wr_ptr increments and goes from DEPTH-1 to 0.
//   - Write while full: the byte is dropped, overrun<=1, and pointers are unchanged. This holds
//     even if a read is accepted in the same cycle.
//   - Read accept: rd_en=1 && !empty, where empty is sampled before the edge. On the next cycle
//     rd_data=mem[rd_ptr] and rd_valid=1; rd_ptr increments and goes from DEPTH-1 to 0.
//     rd_en while empty: ignored, rd_valid=0, and rd_data holds its previous value.
//   - Same cycle, write and read both accepted: count is unchanged and both pointers advance.
//     When empty, a write plus a read stores the byte and rejects the read; count becomes 1.
//   - count = count + wr_acc - rd_acc. It never exceeds DEPTH and never goes below 0.
//   - msg_done: pulses for 1 cycle on the cycle after an accepted write with
//     rx_data==TERM_BYTE. Dropped bytes, including a dropped TERM_BYTE, never pulse it.
//   - overrun: set on a dropped write and cleared by clr_ovr. If both happen in the same
//     cycle, set wins.
//   - rd_valid is deasserted the cycle after the pulse unless another read is accepted.
//     Back-to-back rd_en gives one byte per cycle.
// CONFIGURATION
//   - RX_FRAME_ERR_EN defined: the frame_err and err_cnt ports exist.
//     * rx_valid && frame_err: the byte is never stored, does not affect overrun or msg_done,
//       and err_cnt increments, saturating at 8'hFF.
//     * Reset clears err_cnt.
//   - RX_FRAME_ERR_EN undefined: frame_err and err_cnt are absent, and every rx_valid
//     byte follows the write rules above.
// TESTING
//   1. Reset, then write 8'h41, 8'h42, 8'h43 -> count=3, empty=0. Three rd_en then give
//      rd_data 41,42,43, each with rd_valid one cycle later, and end with empty=1.
//   2. DEPTH=8: write 9 bytes 00..08 -> full=1 after byte 8, byte 08 dropped, overrun=1.
//      Drain gives 00..07. clr_ovr -> overrun=0.
//   3. Wrap: write 6, read 6, write 6 with values 10..15, read all -> 10..15 in order.
//      Pointers wrap and count tracks exactly.
//   4. Write 8'h48, 8'h0A -> msg_done pulses once, 1 cycle after the 0A write.
//      With the store full, writing 0A -> no pulse, and overrun=1.
//   5. Full store with rx_valid and rd_en in the same cycle -> write dropped, count=DEPTH-1.
//      Empty store with both -> count=1 and no rd_valid. Assert rst_n=0 mid-stream ->
//      all outputs are at reset values immediately.
//   6. RX_FRAME_ERR_EN: 3 bytes with frame_err=1 and 1 clean byte 8'h55 -> err_cnt=3,
//      count=1, and the byte read is 55. 300 bad bytes -> err_cnt=8'hFF.

Source files
------------

// File: rtl/rx_byte_store.sv
// rx_byte_store: circular DEPTH x 8 byte store between uart_rx and its consumer (RX_FRAME_ERR_EN adds frame_err/err_cnt).
// Latency: rd_data/rd_valid one cycle after an accepted rd_en; msg_done one cycle after a stored TERM_BYTE.
// Backpressure: none toward the receiver; bytes arriving while full are dropped and flagged in sticky overrun.
module rx_byte_store #(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] TERM_BYTE = 8'h0A,
    localparam int        CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
`ifdef RX_FRAME_ERR_EN
    input  logic          frame_err,
`endif
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overrun,
    input  logic          clr_ovr,
`ifdef RX_FRAME_ERR_EN
    output logic [7:0]    err_cnt,
`endif
    output logic          msg_done
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          bad_byte;
    logic          wr_acc;
    logic          wr_drop;
    logic          rd_acc;

`ifdef RX_FRAME_ERR_EN
    assign bad_byte = rx_valid & frame_err;
`else
    assign bad_byte = 1'b0;
`endif

    // A full store drops the incoming byte even when a read frees a slot this cycle.
    assign wr_acc  = rx_valid & ~bad_byte & ~full;
    assign wr_drop = rx_valid & ~bad_byte & full;
    assign rd_acc  = rd_en & ~empty;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overrun  <= 1'b0;
            msg_done <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr  <= ptr_inc(rd_ptr);
                rd_data <= mem[rd_ptr];
            end
            rd_valid <= rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            msg_done <= wr_acc && (rx_data == TERM_BYTE);
            if (wr_drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef RX_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (bad_byte && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rx_byte_store.sv
// Bench for rx_byte_store: directed vector table, hand-written corner sequences, then random traffic against a queue model.
module tb_rx_byte_store;

    localparam int         DEPTH = 8;
    localparam logic [7:0] TERM  = 8'h0A;
    localparam int         CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overrun;
    logic          clr_ovr;
    logic          msg_done;
`ifdef RX_FRAME_ERR_EN
    logic          frame_err;
    logic [7:0]    err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    rx_byte_store #(.DEPTH(DEPTH), .TERM_BYTE(TERM)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
`ifdef RX_FRAME_ERR_EN
        .frame_err(frame_err),
`endif
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overrun  (overrun),
        .clr_ovr  (clr_ovr),
`ifdef RX_FRAME_ERR_EN
        .err_cnt  (err_cnt),
`endif
        .msg_done (msg_done)
    );

    always #5 clk = ~clk;

    // Reference model: a plain byte queue plus the observable flags.
    logic [7:0] mq[$];
    logic       m_ovr;
    logic       m_rv;
    logic [7:0] m_rd;
    logic       m_md;
    int         m_err;

    task automatic model_reset();
        mq.delete();
        m_ovr = 1'b0;
        m_rv  = 1'b0;
        m_rd  = 8'h00;
        m_md  = 1'b0;
        m_err = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic fe, input logic r, input logic c);
        int  sz;
        logic bad, wr, drop, rd;
        sz   = mq.size();
        bad  = v && fe;
        wr   = v && !bad && (sz < DEPTH);
        drop = v && !bad && (sz == DEPTH);
        rd   = r && (sz > 0);
        m_rv = rd;
        if (rd) m_rd = mq.pop_front();
        if (wr) mq.push_back(d);
        m_md = wr && (d == TERM);
        if (drop) m_ovr = 1'b1;
        else if (c) m_ovr = 1'b0;
        if (bad && m_err < 255) m_err++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " count"}, 32'(count), 32'(mq.size()));
        chk({tag, " empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, " full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, " overrun"}, 32'(overrun), 32'(m_ovr));
        chk({tag, " rd_valid"}, 32'(rd_valid), 32'(m_rv));
        chk({tag, " rd_data"}, 32'(rd_data), 32'(m_rd));
        chk({tag, " msg_done"}, 32'(msg_done), 32'(m_md));
`ifdef RX_FRAME_ERR_EN
        chk({tag, " err_cnt"}, 32'(err_cnt), 32'(m_err));
`endif
    endtask

    // Drive one cycle of inputs, advance the model, and return at posedge+1.
    task automatic cyc(input logic v, input logic [7:0] d, input logic fe, input logic r, input logic c);
        rx_valid = v;
        rx_data  = d;
        rd_en    = r;
        clr_ovr  = c;
`ifdef RX_FRAME_ERR_EN
        frame_err = fe;
`endif
        model_step(v, d, fe, r, c);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rd_en    = 1'b0;
        clr_ovr  = 1'b0;
`ifdef RX_FRAME_ERR_EN
        frame_err = 1'b0;
`endif
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       c;
        int         e_cnt;
        logic       e_rv;
        logic [7:0] e_rd;
        logic       e_ovr;
        logic       e_md;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vec_t vv;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rd_en    = 1'b0;
        clr_ovr  = 1'b0;
`ifdef RX_FRAME_ERR_EN
        frame_err = 1'b0;
`endif
        model_reset();

        //           v     d      r     c     cnt rv    rd     ovr   md
        vecs.push_back('{1'b1, 8'h41, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h42, 1'b0, 1'b0, 2, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h43, 1'b0, 1'b0, 3, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'h41, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h42, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h43, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h43, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h48, 1'b0, 1'b0, 1, 1'b0, 8'h43, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h0A, 1'b0, 1'b0, 2, 1'b0, 8'h43, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b0, 8'h43, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h0A, 1'b1, 1'b0, 2, 1'b1, 8'h48, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h0A, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h0A, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h33, 1'b1, 1'b0, 1, 1'b0, 8'h0A, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h33, 1'b0, 1'b0});

        // Reset state, observed while rst_n is still low.
        #12;
        chk("reset count", 32'(count), 32'd0);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset full", 32'(full), 32'd0);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        chk("reset rd_data", 32'(rd_data), 32'd0);
        chk("reset overrun", 32'(overrun), 32'd0);
        chk("reset msg_done", 32'(msg_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            vv = vecs[i];
            cyc(vv.v, vv.d, 1'b0, vv.r, vv.c);
            chk($sformatf("vec%0d count", i), 32'(count), 32'(vv.e_cnt));
            chk($sformatf("vec%0d empty", i), 32'(empty), 32'(vv.e_cnt == 0));
            chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vv.e_rv));
            chk($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vv.e_rd));
            chk($sformatf("vec%0d overrun", i), 32'(overrun), 32'(vv.e_ovr));
            chk($sformatf("vec%0d msg_done", i), 32'(msg_done), 32'(vv.e_md));
        end

        // Fill past capacity; the ninth byte (a terminator value is not used here) is dropped.
        for (int i = 0; i <= DEPTH; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            check_model("fill");
            if (i == DEPTH - 1) chk("full after 8", 32'(full), 32'd1);
        end
        chk("overrun after drop", 32'(overrun), 32'd1);
        chk("count after drop", 32'(count), 32'(DEPTH));

        // Dropped terminator on a full store: no msg_done.
        cyc(1'b1, TERM, 1'b0, 1'b0, 1'b0);
        chk("dropped term msg_done", 32'(msg_done), 32'd0);
        check_model("full term");

        // Full store, write+read+clr_ovr together: write dropped, overrun set wins.
        cyc(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
        chk("full wr+rd count", 32'(count), 32'(DEPTH - 1));
        chk("full wr+rd overrun", 32'(overrun), 32'd1);
        chk("full wr+rd rd_data", 32'(rd_data), 32'h00);
        check_model("full wr+rd");
        for (int i = 1; i < DEPTH; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            chk("drain rd_data", 32'(rd_data), 32'(i));
            chk("drain rd_valid", 32'(rd_valid), 32'd1);
        end
        chk("drain empty", 32'(empty), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("clr_ovr", 32'(overrun), 32'd0);
        check_model("clr");

        // Wrap-around: pointers cross the end of the array.
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
            chk("wrap count up", 32'(count), 32'(i + 1));
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            chk("wrap rd_data", 32'(rd_data), 32'(8'h10 + 8'(i)));
            chk("wrap count down", 32'(count), 32'(5 - i));
        end
        check_model("wrap");

        // Reset mid-stream with rd_valid and msg_done pulses in flight.
        cyc(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, TERM, 1'b0, 1'b1, 1'b0);
        check_model("pre-reset");
        rst_n = 1'b0;
        #1;
        chk("midrst count", 32'(count), 32'd0);
        chk("midrst empty", 32'(empty), 32'd1);
        chk("midrst rd_valid", 32'(rd_valid), 32'd0);
        chk("midrst rd_data", 32'(rd_data), 32'd0);
        chk("midrst msg_done", 32'(msg_done), 32'd0);
        chk("midrst overrun", 32'(overrun), 32'd0);
        model_reset();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_model("post-reset");

`ifdef RX_FRAME_ERR_EN
        for (int i = 0; i < 3; i++) cyc(1'b1, TERM, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        chk("fe err_cnt 3", 32'(err_cnt), 32'd3);
        chk("fe count 1", 32'(count), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("fe rd_data 55", 32'(rd_data), 32'h55);
        for (int i = 0; i < 300; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
        chk("fe err_cnt sat", 32'(err_cnt), 32'hFF);
        chk("fe no overrun", 32'(overrun), 32'd0);
        check_model("fe");
`endif

        // Random traffic, alternating fill-heavy and drain-heavy phases.
        for (int n = 0; n < 3000; n++) begin
            int         pw, pr;
            logic       v, r, c, fe;
            logic [7:0] d;
            pw = ((n / 300) % 2 == 0) ? 80 : 30;
            pr = ((n / 300) % 2 == 0) ? 30 : 80;
            v  = ($urandom_range(0, 99) < pw);
            r  = ($urandom_range(0, 99) < pr);
            c  = ($urandom_range(0, 19) == 0);
            d  = ($urandom_range(0, 5) == 0) ? TERM : 8'($urandom);
`ifdef RX_FRAME_ERR_EN
            fe = ($urandom_range(0, 9) == 0);
`else
            fe = 1'b0;
`endif
            cyc(v, d, fe, r, c);
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
